// File: rtl/game_pkg.sv
// Shared types for the player jump controller.
// Jump FSM states and the video offset width.
package game_pkg;
  localparam int DIST_W = 10;
  typedef enum logic [1:0] {
    GROUND,
    RISE,
    HOLD,
    FALL
  } jump_state_t;
endpackage

// File: rtl/player_jump_ctrl_if.sv
// Game-side bundle of the jump controller: button, tick, freeze in;
// vertical offset, airborne flag and jump counter out.
interface player_jump_ctrl_if;
  import game_pkg::*;
  logic              jump_btn;
  logic              game_tick;
  logic              freeze;
  logic [DIST_W-1:0] distance;
  logic              airborne;
  logic [7:0]        jump_count;

  modport master (
    output jump_btn, game_tick, freeze,
    input  distance, airborne, jump_count
  );
  modport slave (
    input  jump_btn, game_tick, freeze,
    output distance, airborne, jump_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser, stable-level debouncer and rising-edge pulse.
// Level flips only after CYCLES consecutive samples of the new value.
module btn_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          s1, s2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      press   <= level & ~level_q;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/player_jump_ctrl.sv
// Jump button to vertical player offset: rise / hang / fall per game tick.
// Define PLAYER_DOUBLE_JUMP_EN to allow one extra jump per airtime.
module player_jump_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_HEIGHT      = 120,
  parameter int RISE_STEP       = 8,
  parameter int FALL_STEP       = 6,
  parameter int HANG_TICKS      = 4
) (
  input logic               clk,
  input logic               reset,
  player_jump_ctrl_if.slave bus
);
  localparam int HW = (HANG_TICKS < 1) ? 1
                    : $clog2(HANG_TICKS + 1);
  localparam logic [10:0] MAX11 = 11'(MAX_HEIGHT);
  localparam logic [10:0] R11   = 11'(RISE_STEP);
  localparam logic [10:0] F11   = 11'(FALL_STEP);
  localparam logic [DIST_W-1:0] FIRST =
    (RISE_STEP > MAX_HEIGHT) ? DIST_W'(MAX_HEIGHT)
                             : DIST_W'(RISE_STEP);
  localparam logic [HW-1:0] HANG_INIT = HW'(HANG_TICKS);
  localparam jump_state_t PEAK =
    (HANG_TICKS == 0) ? FALL : HOLD;

  jump_state_t       state_q, state_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [HW-1:0]     hang_q, hang_d;
  logic [7:0]        jc_q, jc_d;
  logic              req_q, req_d;
  logic              air_q;
  logic              press;
  logic              step;
  logic              apex;
  logic [10:0]       up, up_c, dn;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic              dj_q, dj_d;
`endif

  btn_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk),
    .rst_n(reset),
    .btn  (bus.jump_btn),
    .press(press)
  );

  // 11-bit headroom so the clamp sees the true sum
  assign up   = {1'b0, dist_q} + R11;
  assign up_c = (up > MAX11) ? MAX11 : up;
  assign dn   = ({1'b0, dist_q} >= F11)
              ? {1'b0, dist_q} - F11 : '0;
  assign apex = (up_c == MAX11);
  assign step = bus.game_tick & ~bus.freeze;

  always_comb begin
    state_d = state_q;
    dist_d  = dist_q;
    hang_d  = hang_q;
    jc_d    = jc_q;
    req_d   = req_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_d    = dj_q;
`endif
    if (bus.freeze)         req_d = 1'b0;
    else if (press)         req_d = 1'b1;
    else if (bus.game_tick) req_d = 1'b0;

    if (step) begin
      unique case (state_q)
        GROUND: begin
          if (req_q) begin
            state_d = RISE;
            dist_d  = FIRST;
            jc_d    = jc_q + 8'd1;
          end
        end
        RISE: begin
          dist_d = up_c[DIST_W-1:0];
          if (apex) begin
            state_d = PEAK;
            hang_d  = HANG_INIT;
          end
        end
        HOLD: begin
          hang_d = hang_q - HW'(1);
          if (hang_q == HW'(1)) state_d = FALL;
        end
        FALL: begin
          dist_d = dn[DIST_W-1:0];
          if (dn == '0) begin
            state_d = GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_d    = 1'b0;
`endif
          end
        end
        default: ;
      endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
      // mid-air restart overrides the normal profile step
      if (req_q && !dj_q && state_q != GROUND) begin
        dist_d  = up_c[DIST_W-1:0];
        jc_d    = jc_q + 8'd1;
        dj_d    = 1'b1;
        state_d = apex ? PEAK : RISE;
        if (apex) hang_d = HANG_INIT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GROUND;
      dist_q  <= '0;
      hang_q  <= '0;
      jc_q    <= '0;
      req_q   <= 1'b0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dist_q  <= dist_d;
      hang_q  <= hang_d;
      jc_q    <= jc_d;
      req_q   <= req_d;
      air_q   <= (state_d != GROUND);
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dj_q <= 1'b0;
    else        dj_q <= dj_d;
  end
`endif

  assign bus.distance   = dist_q;
  assign bus.airborne   = air_q;
  assign bus.jump_count = jc_q;
endmodule

// File: tb/tb_player_jump_ctrl.sv
// Bench for player_jump_ctrl: directed scenarios plus random stimulus
// against a trajectory-queue reference model.
module tb_player_jump_ctrl;
  import game_pkg::*;

  localparam int DEB  = 16;
  localparam int MAXH = 120;
  localparam int RS   = 8;
  localparam int FS   = 6;
  localparam int HANG = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_jump_ctrl_if bus ();

  player_jump_ctrl #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // reference model: future distances queued per jump
  int path[$];
  int m_dist, m_jc, run_len;
  bit m_air, m_dj, m_req, run_val, db_lvl;
  bit pend[4];

  task automatic build_path(int from);
    int d;
    path.delete();
    d = from + RS;
    while (d < MAXH) begin
      path.push_back(d);
      d += RS;
    end
    path.push_back(MAXH);
    repeat (HANG) path.push_back(MAXH);
    d = MAXH - FS;
    while (d > 0) begin
      path.push_back(d);
      d -= FS;
    end
    path.push_back(0);
  endtask

  task automatic model_reset();
    path.delete();
    m_dist = 0; m_jc = 0; m_air = 0; m_dj = 0;
    m_req = 0; run_val = 0; run_len = 0; db_lvl = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
  endtask

  task automatic model_step();
    bit b, t, f, evt;
    b = bus.jump_btn; t = bus.game_tick; f = bus.freeze;
    if (!rst_n) begin
      model_reset();
      return;
    end
    evt = pend[3];
    pend[3] = pend[2]; pend[2] = pend[1];
    pend[1] = pend[0]; pend[0] = 0;
    if (b == run_val) run_len++;
    else begin
      run_val = b;
      run_len = 1;
    end
    if (run_val != db_lvl && run_len >= DEB) begin
      db_lvl = run_val;
      if (db_lvl) pend[0] = 1;
    end
    if (t && !f) begin
      if (m_req && !m_air) begin
        build_path(0);
        m_jc = (m_jc + 1) % 256;
        m_dj = 0;
      end
`ifdef PLAYER_DOUBLE_JUMP_EN
      else if (m_req && m_air && !m_dj) begin
        build_path(m_dist);
        m_jc = (m_jc + 1) % 256;
        m_dj = 1;
      end
`endif
      if (path.size() > 0) begin
        m_dist = path.pop_front();
        m_air = (path.size() > 0);
      end
    end
    if (f)        m_req = 0;
    else if (evt) m_req = 1;
    else if (t)   m_req = 0;
  endtask

  function automatic bit falling();
    return m_air && path.size() > 0 && path[0] < m_dist;
  endfunction

  task automatic cyc(bit t);
    bus.game_tick = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("dist", bus.distance, m_dist);
    check("air", bus.airborne, m_air);
    check("jcnt", bus.jump_count, m_jc);
    check("dist_le_max", bus.distance <= MAXH, 1);
    bus.game_tick = 1'b0;
  endtask

  task automatic ticks(int n, int gap);
    repeat (n) begin
      repeat (gap - 1) cyc(0);
      cyc(1);
    end
  endtask

  task automatic press(int hold, int after);
    bus.jump_btn = 1'b1;
    repeat (hold) cyc(0);
    bus.jump_btn = 1'b0;
    repeat (after) cyc(0);
  endtask

  task automatic tick_until(int target, bit want_fall, string tag);
    int n;
    n = 0;
    while (!(m_dist == target && (!want_fall || falling()))
           && n < 80) begin
      ticks(1, 3);
      n++;
    end
    check(tag, bus.distance, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got 0 want 1");
    $fatal(1);
  end

  initial begin
    int peak, n120, nair, hold;
    int exp_jc;
    model_reset();
    bus.jump_btn = 1'b1;
    bus.game_tick = 1'b0;
    bus.freeze = 1'b0;
    @(negedge clk);
    repeat (3) cyc(0);
    repeat (3) cyc(1);
    check("rst_dist", bus.distance, 0);
    check("rst_air", bus.airborne, 0);
    check("rst_jc", bus.jump_count, 0);
    bus.jump_btn = 1'b0;
    rst_n = 1'b1;
    ticks(100, 4);
    check("idle_dist", bus.distance, 0);
    check("idle_jc", bus.jump_count, 0);

    // clean jump
    bus.jump_btn = 1'b1;
    repeat (40) cyc(0);
    bus.jump_btn = 1'b0;
    peak = 0; n120 = 0; nair = 0;
    for (int i = 0; i < 45; i++) begin
      ticks(1, 3);
      if (i == 0) check("first_step", bus.distance, RS);
      if (bus.distance > peak) peak = bus.distance;
      if (bus.distance == MAXH) n120++;
      if (bus.airborne) nair++;
    end
    check("peak", peak, MAXH);
    check("apex_ticks", n120, 1 + HANG);
    check("air_ticks", nair, 38);
    check("clean_jc", bus.jump_count, 1);
    check("landed", bus.distance, 0);

    // bouncing button
    for (int i = 0; i < 40; i++) begin
      bus.jump_btn = ~bus.jump_btn;
      for (int k = 0; k < 5; k++) cyc(k == 2);
    end
    bus.jump_btn = 1'b0;
    ticks(20, 3);
    check("bounce_jc", bus.jump_count, 1);
    check("bounce_dist", bus.distance, 0);

    // freeze mid-rise
    press(40, 0);
    tick_until(64, 0, "frz_reach");
    bus.freeze = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.jump_btn = (i < 14);
      ticks(1, 3);
    end
    check("frz_dist", bus.distance, 64);
    check("frz_jc", bus.jump_count, 2);
    bus.freeze = 1'b0;
    ticks(1, 3);
    check("frz_resume", bus.distance, 72);
    ticks(40, 3);
    check("frz_land", bus.distance, 0);

    // press while falling
    press(40, 0);
    tick_until(96, 1, "air_reach");
    press(30, 25);
    ticks(1, 3);
`ifdef PLAYER_DOUBLE_JUMP_EN
    check("air_step", bus.distance, 104);
    exp_jc = 4;
`else
    check("air_step", bus.distance, 90);
    exp_jc = 3;
`endif
    check("air_jc", bus.jump_count, exp_jc);
    ticks(2, 3);
    press(30, 25);
    ticks(2, 3);
    check("third_jc", bus.jump_count, exp_jc);
    ticks(60, 3);
    check("air_land", bus.distance, 0);

    // reset at apex
    press(40, 0);
    tick_until(MAXH, 0, "rst_reach");
    rst_n = 1'b0;
    #1;
    check("mid_rst_dist", bus.distance, 0);
    check("mid_rst_air", bus.airborne, 0);
    cyc(0);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_dist", bus.distance, 0);

    // random traffic
    hold = 0;
    repeat (5000) begin
      if (hold == 0) begin
        bus.jump_btn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 199) == 0)
        bus.freeze = ~bus.freeze;
      cyc($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
